// File: rtl/transmisor_angulos_serial.sv
`default_nettype none
// ============================================================================
// Module      : transmisor_angulos_serial
// Description : UART-style (8N1, LSB first) transmitter for servo angle
//               frames. On a request it latches three 8-bit angles and sends
//               HEADER, ang2, ang3, ang4 (plus an optional checksum byte).
//               Angles equal to 8'hFF are sent as 8'hFE so the header byte
//               stays unique on the line.
// Config      : define CHECKSUM_EN to append a 5th byte holding
//               (ang2 + ang3 + ang4) mod 256 of the clamped angles, itself
//               clamped from 8'hFF to 8'hFE.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               enviar       - frame request, sampled when idle
//               ang_servo_2/3/4 - 8-bit angles
//               canal_serial - serial line, idle high
//               ocupado      - high while a frame is on the line
//               trama_lista  - one-cycle pulse when a frame completes
// Revision    : 1.0 - initial release
// ============================================================================
module transmisor_angulos_serial #(
   parameter int         CLKS_PER_BIT = 1000,
   parameter logic [7:0] HEADER       = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enviar,
   input  logic [7:0] ang_servo_2,
   input  logic [7:0] ang_servo_3,
   input  logic [7:0] ang_servo_4,
   output logic       canal_serial,
   output logic       ocupado,
   output logic       trama_lista
);

   localparam int c_TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_TIMER_W-1:0] c_LAST_TICK = c_TIMER_W'(CLKS_PER_BIT - 1);
`ifdef CHECKSUM_EN
   localparam logic [2:0] c_LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] c_LAST_BYTE = 3'd3;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                 r_state;
   logic [c_TIMER_W-1:0]   r_timer;
   logic [2:0]             r_bit_idx;
   logic [2:0]             r_byte_idx;
   logic [7:0]             r_ang2;
   logic [7:0]             r_ang3;
   logic [7:0]             r_ang4;
   logic                   r_line;
   logic                   r_ocupado;
   logic                   r_trama;
   logic                   r_enviar_prev;

   logic                   w_tick;
   logic                   w_start;
   logic [2:0]             w_next_bit;
   logic [7:0]             w_byte;

   // Payload bytes must never look like the sync byte.
   function automatic logic [7:0] clamp_ff(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFE : v;
   endfunction

`ifdef CHECKSUM_EN
   logic [7:0] r_cks;
   logic [7:0] w_sum;
   logic [7:0] w_cks;
   assign w_sum = clamp_ff(ang_servo_2) + clamp_ff(ang_servo_3) + clamp_ff(ang_servo_4);
   assign w_cks = clamp_ff(w_sum);
`endif

   assign w_tick     = (r_timer == c_LAST_TICK);
   assign w_next_bit = r_bit_idx + 3'd1;

   // A new frame starts from IDLE, or straight out of DONE when enviar has
   // been held high across the end of the previous frame. A request that
   // first appears in the DONE cycle is not accepted there.
   assign w_start = enviar &&
                    ((r_state == S_IDLE) || ((r_state == S_DONE) && r_enviar_prev));

   always_comb begin
      w_byte = HEADER;
      case (r_byte_idx)
         3'd1:    w_byte = r_ang2;
         3'd2:    w_byte = r_ang3;
         3'd3:    w_byte = r_ang4;
`ifdef CHECKSUM_EN
         3'd4:    w_byte = r_cks;
`endif
         default: w_byte = HEADER;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_bit_idx     <= '0;
         r_byte_idx    <= '0;
         r_ang2        <= '0;
         r_ang3        <= '0;
         r_ang4        <= '0;
         r_line        <= 1'b1;
         r_ocupado     <= 1'b0;
         r_trama       <= 1'b0;
         r_enviar_prev <= 1'b0;
`ifdef CHECKSUM_EN
         r_cks         <= '0;
`endif
      end else begin
         r_enviar_prev <= enviar;
         r_trama       <= 1'b0;
         if (w_start) begin
            r_ang2     <= clamp_ff(ang_servo_2);
            r_ang3     <= clamp_ff(ang_servo_3);
            r_ang4     <= clamp_ff(ang_servo_4);
`ifdef CHECKSUM_EN
            r_cks      <= w_cks;
`endif
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_timer    <= '0;
            r_ocupado  <= 1'b1;
            r_line     <= 1'b0;
            r_state    <= S_START;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_line  <= 1'b1;
                  r_timer <= '0;
               end
               S_START: begin
                  if (w_tick) begin
                     r_timer   <= '0;
                     r_bit_idx <= '0;
                     r_line    <= w_byte[0];
                     r_state   <= S_DATA;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               S_DATA: begin
                  if (w_tick) begin
                     r_timer <= '0;
                     if (r_bit_idx == 3'd7) begin
                        r_line  <= 1'b1;
                        r_state <= S_STOP;
                     end else begin
                        r_bit_idx <= w_next_bit;
                        r_line    <= w_byte[w_next_bit];
                     end
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               S_STOP: begin
                  if (w_tick) begin
                     r_timer <= '0;
                     if (r_byte_idx == c_LAST_BYTE) begin
                        r_trama   <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_line    <= 1'b1;
                        r_state   <= S_DONE;
                     end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_line     <= 1'b0;
                        r_state    <= S_START;
                     end
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               S_DONE: begin
                  r_line  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_line    <= 1'b1;
                  r_ocupado <= 1'b0;
                  r_timer   <= '0;
                  r_state   <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign canal_serial = r_line;
   assign ocupado      = r_ocupado;
   assign trama_lista  = r_trama;

endmodule
`default_nettype wire

// File: tb/tb_transmisor_angulos_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_transmisor_angulos_serial
// Description : Self-checking bench for transmisor_angulos_serial with
//               CLKS_PER_BIT=4. Expected line/ocupado/trama_lista values per
//               cycle come from a byte-level frame model (CHECKSUM_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transmisor_angulos_serial;

   localparam int c_CPB = 4;
`ifdef CHECKSUM_EN
   localparam int c_NB = 5;
`else
   localparam int c_NB = 4;
`endif
   localparam int c_L = c_NB * 10 * c_CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enviar = 1'b0;
   logic [7:0] ang_servo_2 = 8'h00;
   logic [7:0] ang_servo_3 = 8'h00;
   logic [7:0] ang_servo_4 = 8'h00;
   logic       canal_serial;
   logic       ocupado;
   logic       trama_lista;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_b [0:4];
   logic [2:0] obs   [1:512];

   transmisor_angulos_serial #(.CLKS_PER_BIT(c_CPB), .HEADER(8'hFF)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enviar       (enviar),
      .ang_servo_2  (ang_servo_2),
      .ang_servo_3  (ang_servo_3),
      .ang_servo_4  (ang_servo_4),
      .canal_serial (canal_serial),
      .ocupado      (ocupado),
      .trama_lista  (trama_lista)
   );

   always #5 clk = ~clk;

   // Frame model: bytes as they should appear on the line.
   function automatic void set_exp(input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
      int c2, c3, c4, s;
      c2 = (a2 == 8'd255) ? 254 : int'(a2);
      c3 = (a3 == 8'd255) ? 254 : int'(a3);
      c4 = (a4 == 8'd255) ? 254 : int'(a4);
      s  = (c2 + c3 + c4) % 256;
      if (s == 255) s = 254;
      exp_b[0] = 8'hFF;
      exp_b[1] = 8'(c2);
      exp_b[2] = 8'(c3);
      exp_b[3] = 8'(c4);
      exp_b[4] = 8'(s);
   endfunction

   // Expected {line, ocupado, trama_lista} in cycle k after the sampling edge.
   function automatic logic [2:0] exp_sig(input int k);
      int idx, slot, by, pos;
      logic b;
      if (k == c_L + 1) return 3'b101;
      idx  = k - 1;
      slot = idx / c_CPB;
      by   = slot / 10;
      pos  = slot % 10;
      if (pos == 0)      b = 1'b0;
      else if (pos == 9) b = 1'b1;
      else               b = exp_b[by][pos-1];
      return {b, 2'b10};
   endfunction

   task automatic start_frame(input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
      @(negedge clk);
      ang_servo_2 = a2;
      ang_servo_3 = a3;
      ang_servo_4 = a4;
      enviar      = 1'b1;
      set_exp(a2, a3, a4);
      @(posedge clk);
   endtask

   // Records outputs for cycles 1..ncyc after the sampling edge and applies
   // optional mid-frame stimulus.
   task automatic capture(input int ncyc, input int release_at, input int repulse_at, input int change_at);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         obs[k] = {canal_serial, ocupado, trama_lista};
         if (k == release_at) enviar = 1'b0;
         if (repulse_at > 0 && k == repulse_at) enviar = 1'b1;
         if (repulse_at > 0 && k == repulse_at + 1) enviar = 1'b0;
         if (k == change_at) begin
            ang_servo_2 = 8'($urandom_range(0, 255));
            ang_servo_3 = 8'($urandom_range(0, 255));
            ang_servo_4 = 8'($urandom_range(0, 255));
         end
      end
   endtask

   task automatic test_reset;
      rst_n  = 1'b0;
      enviar = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
         bad++;
         $display("FAIL reset_state got=%b want=100", {canal_serial, ocupado, trama_lista});
      end
      total++;
      rst_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%b want=100", k, {canal_serial, ocupado, trama_lista});
         end
         total++;
      end
   endtask

   task automatic test_basic;
      start_frame(8'h10, 8'h80, 8'h7F);
      capture(c_L + 1, 1, 0, 0);
      for (int k = 1; k <= c_L + 1; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL basic cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
   endtask

   task automatic test_clamp;
      start_frame(8'h21, 8'hFF, 8'h42);
      capture(c_L + 1, 1, 0, 0);
      for (int k = 1; k <= c_L + 1; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL clamp cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
   endtask

   task automatic test_midframe;
      start_frame(8'h5A, 8'h03, 8'hC4);
      capture(c_L + 1, 1, 50, 60);
      for (int k = 1; k <= c_L + 1; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL midframe cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
            bad++;
            $display("FAIL midframe_no_second cyc=%0d got=%b want=100", k, {canal_serial, ocupado, trama_lista});
         end
         total++;
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] e;
      start_frame(8'h01, 8'hFE, 8'h99);
      capture(2 * c_L + 2, c_L + 6, 0, 0);
      for (int k = 1; k <= 2 * c_L + 2; k++) begin
         e = (k <= c_L + 1) ? exp_sig(k) : exp_sig(k - (c_L + 1));
         if (obs[k] !== e) begin
            bad++;
            $display("FAIL back_to_back cyc=%0d got=%b want=%b", k, obs[k], e);
         end
         total++;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
            bad++;
            $display("FAIL back_to_back_idle cyc=%0d got=%b want=100", k, {canal_serial, ocupado, trama_lista});
         end
         total++;
      end
   endtask

   task automatic test_reset_midframe;
      start_frame(8'h10, 8'h80, 8'h7F);
      capture(100, 1, 0, 0);
      for (int k = 1; k <= 100; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL abort_pre cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
      rst_n = 1'b0;
      #1;
      if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
         bad++;
         $display("FAIL abort_async got=%b want=100", {canal_serial, ocupado, trama_lista});
      end
      total++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ({canal_serial, ocupado, trama_lista} !== 3'b100) begin
            bad++;
            $display("FAIL abort_idle cyc=%0d got=%b want=100", k, {canal_serial, ocupado, trama_lista});
         end
         total++;
      end
      start_frame(8'h33, 8'h44, 8'h55);
      capture(c_L + 1, 1, 0, 0);
      for (int k = 1; k <= c_L + 1; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL abort_resend cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
   endtask

   task automatic test_random;
      logic [7:0] a [0:2];
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 3; i++) begin
            a[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         end
         start_frame(a[0], a[1], a[2]);
         capture(c_L + 1, 1, 0, 0);
         for (int k = 1; k <= c_L + 1; k++) begin
            if (obs[k] !== exp_sig(k)) begin
               bad++;
               $display("FAIL random f=%0d cyc=%0d got=%b want=%b", f, k, obs[k], exp_sig(k));
            end
            total++;
         end
      end
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum;
      start_frame(8'hFE, 8'h01, 8'h00);
      capture(c_L + 1, 1, 0, 0);
      for (int k = 1; k <= c_L + 1; k++) begin
         if (obs[k] !== exp_sig(k)) begin
            bad++;
            $display("FAIL checksum_clamp cyc=%0d got=%b want=%b", k, obs[k], exp_sig(k));
         end
         total++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_midframe();
      test_back_to_back();
      test_reset_midframe();
      test_random();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
